// File: rtl/timer_ctrl_if.sv
// Command and status bundle for timer_ctrl.
// The master side issues start/pause/clear with direction and preset.
// The slave side (the timer) returns count, state, running and done.
interface timer_ctrl_if #(
    parameter int DATAWIDTH = 4
);
    logic                 start;
    logic                 pause;
    logic                 clear;
    logic                 down;
    logic [DATAWIDTH-1:0] preset;
    logic [DATAWIDTH-1:0] count;
    logic [1:0]           state;
    logic                 running;
    logic                 done;

    modport master (
        output start, pause, clear, down, preset,
        input  count, state, running, done
    );

    modport slave (
        input  start, pause, clear, down, preset,
        output count, state, running, done
    );
endinterface

// File: rtl/timer_ctrl.sv
// Prescaled up/down timer with a four-state run/pause/done controller.
// A start from IDLE or DONE latches direction and target, then the count
// steps once every PRESCALE cycles until it lands on the target.
// Every output comes straight from a register or from the state register.
module timer_ctrl #(
    parameter int DATAWIDTH = 4,
    parameter int PRESCALE  = 4
) (
    input  logic       clk,
    input  logic       rst,
    timer_ctrl_if.slave bus
);

    // A PRESCALE of 1 would give a zero-width prescaler, so keep at least one bit.
    localparam int PSW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PSW-1:0]       PRESC_LAST = PSW'(PRESCALE - 1);
    localparam logic [PSW-1:0]       PRESC_ONE  = PSW'(1);
    localparam logic [DATAWIDTH-1:0] COUNT_ONE  = DATAWIDTH'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        PAUSED = 2'b10,
        DONE   = 2'b11
    } state_t;

    state_t               state_r,     state_n;
    logic [DATAWIDTH-1:0] count_r,     count_n;
    logic [PSW-1:0]       prescaler_r, prescaler_n;
    logic                 mode_r,      mode_n;
    logic [DATAWIDTH-1:0] target_r,    target_n;
    logic                 done_r,      done_n;
    logic [DATAWIDTH-1:0] stepped;

    // Registers all timer state; reset wins over every command.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            count_r     <= '0;
            prescaler_r <= '0;
            mode_r      <= 1'b0;
            target_r    <= '0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_n;
            count_r     <= count_n;
            prescaler_r <= prescaler_n;
            mode_r      <= mode_n;
            target_r    <= target_n;
            done_r      <= done_n;
        end
    end

    // Next-state logic: clear beats start, start beats pause, and done only
    // rises on the edge that enters DONE so it lasts a single cycle.
    always_comb begin
        state_n     = state_r;
        count_n     = count_r;
        prescaler_n = prescaler_r;
        mode_n      = mode_r;
        target_n    = target_r;
        done_n      = 1'b0;
        stepped     = mode_r ? (count_r - COUNT_ONE) : (count_r + COUNT_ONE);

        if (bus.clear) begin
            state_n     = IDLE;
            count_n     = '0;
            prescaler_n = '0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (bus.start) begin
                        mode_n      = bus.down;
                        target_n    = bus.down ? '0 : bus.preset;
                        count_n     = bus.down ? bus.preset : '0;
                        prescaler_n = '0;
                        if (bus.preset == '0) begin
                            state_n = DONE;
                            done_n  = 1'b1;
                        end else begin
                            state_n = RUN;
                        end
                    end
                end
                RUN: begin
                    if (bus.pause) begin
                        state_n = PAUSED;
                    end else if (prescaler_r == PRESC_LAST) begin
                        prescaler_n = '0;
                        count_n     = stepped;
                        if (stepped == target_r) begin
                            state_n = DONE;
                            done_n  = 1'b1;
                        end
                    end else begin
                        prescaler_n = prescaler_r + PRESC_ONE;
                    end
                end
                PAUSED: begin
                    if (bus.start) begin
                        state_n = RUN;
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    assign bus.count   = count_r;
    assign bus.state   = state_r;
    assign bus.running = (state_r == RUN);
    assign bus.done    = done_r;

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl (DATAWIDTH=4, PRESCALE=4).
// The reference model tracks elapsed run cycles and derives the count
// arithmetically; literal checks along the scenarios pin that model.
module tb_timer_ctrl;

    localparam int DW = 4;
    localparam int P  = 4;
    localparam int S_IDLE = 0, S_RUN = 1, S_PAUSED = 2, S_DONE = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   checkEnable = 1'b0;
    int   checkCount = 0;
    int   passCount  = 0;

    // Reference model state
    int m_state   = S_IDLE;
    int m_load    = 0;
    int m_dir     = 1;
    int m_elapsed = 0;
    int m_need    = 0;
    int m_done    = 0;

    timer_ctrl_if #(.DATAWIDTH(DW)) bus ();

    timer_ctrl #(.DATAWIDTH(DW), .PRESCALE(P)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    function automatic int modelCount();
        int v;
        v = (m_load + m_dir * (m_elapsed / P)) % (1 << DW);
        if (v < 0) v = v + (1 << DW);
        return v;
    endfunction

    // Model: a run needs preset*P cycles in RUN; count is load plus whole steps taken.
    always @(posedge clk) begin
        m_done <= 0;
        if (rst) begin
            m_state   <= S_IDLE;
            m_load    <= 0;
            m_dir     <= 1;
            m_elapsed <= 0;
            m_need    <= 0;
        end else if (bus.clear) begin
            m_state   <= S_IDLE;
            m_load    <= 0;
            m_elapsed <= 0;
        end else if ((m_state == S_IDLE || m_state == S_DONE) && bus.start) begin
            m_load    <= bus.down ? int'(bus.preset) : 0;
            m_dir     <= bus.down ? -1 : 1;
            m_need    <= int'(bus.preset) * P;
            m_elapsed <= 0;
            if (bus.preset == '0) begin
                m_state <= S_DONE;
                m_done  <= 1;
            end else begin
                m_state <= S_RUN;
            end
        end else if (m_state == S_RUN && !bus.pause) begin
            m_elapsed <= m_elapsed + 1;
            if (m_elapsed + 1 == m_need) begin
                m_state <= S_DONE;
                m_done  <= 1;
            end
        end else if (m_state == S_RUN) begin
            m_state <= S_PAUSED;
        end else if (m_state == S_PAUSED && bus.start) begin
            m_state <= S_RUN;
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checkCount++;
        if (actual == expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d at time %0t", name, actual, expected, $time);
        end
    endtask

    // Every-cycle comparison against the model on the falling edge.
    always @(negedge clk) begin
        if (checkEnable) begin
            checkOutput("cyc_count",   int'(bus.count),   modelCount());
            checkOutput("cyc_state",   int'(bus.state),   m_state);
            checkOutput("cyc_running", int'(bus.running), (m_state == S_RUN) ? 1 : 0);
            checkOutput("cyc_done",    int'(bus.done),    m_done);
        end
    end

    task automatic applyStimulus(input logic s, input logic p, input logic c, input logic d,
                                 input logic [DW-1:0] pr, input logic r, input int n);
        bus.start  = s;
        bus.pause  = p;
        bus.clear  = c;
        bus.down   = d;
        bus.preset = pr;
        rst        = r;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkLit(input string tag, input int c, input int st, input int dn);
        checkOutput({tag, "_count"}, int'(bus.count), c);
        checkOutput({tag, "_state"}, int'(bus.state), st);
        checkOutput({tag, "_done"},  int'(bus.done),  dn);
        checkOutput({tag, "_running"}, int'(bus.running), (st == S_RUN) ? 1 : 0);
    endtask

    initial begin
        bus.start = 1'b0; bus.pause = 1'b0; bus.clear = 1'b0;
        bus.down = 1'b0; bus.preset = '0;

        // Reset with a start pending: reset must win.
        applyStimulus(1, 0, 0, 1, 4'd5, 1, 2);
        checkEnable = 1'b1;
        checkLit("reset", 0, S_IDLE, 0);
        applyStimulus(0, 0, 0, 0, 4'd0, 0, 2);
        checkLit("idle", 0, S_IDLE, 0);

        // Count down from 3.
        applyStimulus(1, 0, 0, 1, 4'd3, 0, 1);
        checkLit("dn_E0", 3, S_RUN, 0);
        applyStimulus(0, 0, 0, 1, 4'd3, 0, 4);
        checkLit("dn_E4", 2, S_RUN, 0);
        applyStimulus(0, 0, 0, 1, 4'd3, 0, 4);
        checkLit("dn_E8", 1, S_RUN, 0);
        applyStimulus(0, 0, 0, 1, 4'd3, 0, 4);
        checkLit("dn_E12", 0, S_DONE, 1);
        applyStimulus(0, 0, 0, 1, 4'd3, 0, 1);
        checkLit("dn_E13", 0, S_DONE, 0);

        // Count up to 2, then restart up to 1 from DONE.
        applyStimulus(1, 0, 0, 0, 4'd2, 0, 1);
        checkLit("up_E0", 0, S_RUN, 0);
        applyStimulus(0, 0, 0, 0, 4'd2, 0, 4);
        checkLit("up_E4", 1, S_RUN, 0);
        applyStimulus(0, 0, 0, 0, 4'd2, 0, 4);
        checkLit("up_E8", 2, S_DONE, 1);
        applyStimulus(0, 0, 0, 0, 4'd2, 0, 1);
        checkLit("up_E9", 2, S_DONE, 0);
        applyStimulus(1, 0, 0, 0, 4'd1, 0, 1);
        checkLit("up1_E0", 0, S_RUN, 0);
        applyStimulus(0, 0, 0, 0, 4'd1, 0, 4);
        checkLit("up1_E4", 1, S_DONE, 1);

        // Pause/resume: down from 5, pause after E6, resume at E16.
        applyStimulus(1, 0, 0, 1, 4'd5, 0, 1);
        applyStimulus(0, 0, 0, 1, 4'd5, 0, 6);
        checkLit("pz_E6", 4, S_RUN, 0);
        applyStimulus(0, 1, 0, 1, 4'd5, 0, 1);
        checkLit("pz_E7", 4, S_PAUSED, 0);
        applyStimulus(0, 1, 0, 0, 4'd9, 0, 8);
        checkLit("pz_E15", 4, S_PAUSED, 0);
        applyStimulus(1, 0, 0, 1, 4'd5, 0, 1);
        checkLit("pz_E16", 4, S_RUN, 0);
        applyStimulus(0, 0, 0, 1, 4'd5, 0, 2);
        checkLit("pz_E18", 3, S_RUN, 0);
        applyStimulus(0, 0, 0, 1, 4'd5, 0, 11);
        checkLit("pz_E29", 1, S_RUN, 0);
        applyStimulus(0, 0, 0, 1, 4'd5, 0, 1);
        checkLit("pz_E30", 0, S_DONE, 1);

        // Zero preset and command priority.
        applyStimulus(1, 0, 0, 1, 4'd0, 0, 1);
        checkLit("zero", 0, S_DONE, 1);
        applyStimulus(0, 0, 0, 1, 4'd0, 0, 1);
        checkLit("zero_after", 0, S_DONE, 0);
        applyStimulus(1, 0, 1, 1, 4'd3, 0, 1);
        checkLit("start_clear", 0, S_IDLE, 0);
        applyStimulus(1, 0, 0, 1, 4'd3, 0, 1);
        checkLit("prio_run", 3, S_RUN, 0);
        applyStimulus(1, 1, 0, 1, 4'd3, 0, 1);
        checkLit("start_pause", 3, S_PAUSED, 0);
        applyStimulus(0, 0, 1, 1, 4'd3, 0, 1);
        checkLit("clear", 0, S_IDLE, 0);

        // Full 15..0 run with inputs disturbed mid-run.
        applyStimulus(1, 0, 0, 1, 4'd15, 0, 1);
        checkLit("wrap_E0", 15, S_RUN, 0);
        applyStimulus(0, 0, 0, 1, 4'd15, 0, 4);
        checkLit("wrap_E4", 14, S_RUN, 0);
        applyStimulus(0, 0, 0, 0, 4'd7, 0, 55);
        checkLit("wrap_E59", 1, S_RUN, 0);
        applyStimulus(0, 0, 0, 0, 4'd7, 0, 1);
        checkLit("wrap_E60", 0, S_DONE, 1);

        // Reset mid-run abandons it without a done pulse.
        applyStimulus(1, 0, 0, 1, 4'd15, 0, 1);
        applyStimulus(0, 0, 0, 1, 4'd15, 0, 29);
        checkLit("rst_E29", 8, S_RUN, 0);
        applyStimulus(0, 0, 0, 1, 4'd15, 1, 1);
        checkLit("rst_E30", 0, S_IDLE, 0);
        applyStimulus(0, 0, 0, 1, 4'd15, 0, 5);
        checkLit("rst_wait", 0, S_IDLE, 0);

        checkEnable = 1'b0;
        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
